word_serializer_param: RTL and testbench

- Parametrised successor to the fixed 32b-to-8b word converter.
- Accepts one IN_W-bit word per valid/ready handshake and emits it as RATIO = IN_W/OUT_W narrow slices on consecutive lane-clock cycles, MSB-first or LSB-first.
- Contains a one-word skid buffer, so back-to-back words stream with no gap cycles.
- Downstream backpressure (out_ready) is supported.
- Sits between the word-rate datapath and the byte-lane/serialiser stages, in the lane-rate clock domain.

---
 rtl/word_ser_pkg.sv | 25 ++
 rtl/word_skid_buf.sv | 42 ++++
 rtl/word_serializer_param.sv | 151 +++++++++++++++
 tb/tb_word_serializer_param.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/word_ser_pkg.sv
// Shared types and elaboration-time helpers for the parametrised word serialiser.
package word_ser_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StActive,
    StFull
  } ser_state_e;

  function automatic bit params_legal(int unsigned in_w, int unsigned out_w);
    if (out_w == 0) return 1'b0;
    return ((in_w % out_w) == 0) && ((in_w / out_w) >= 2);
  endfunction

  function automatic int unsigned cnt_width(int unsigned ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  // Bit offset of slice idx within the word; caller shifts the word down by this amount.
  function automatic int unsigned slice_offset(int unsigned in_w, int unsigned out_w,
                                               int unsigned idx, bit msb_first);
    return msb_first ? (in_w - (idx + 1) * out_w) : (idx * out_w);
  endfunction

endpackage

// File: rtl/word_skid_buf.sv
// One-entry skid buffer holding the word that arrives while the shift register is busy.
module word_skid_buf #(
  parameter int unsigned W = 32
) (
  input  logic         clk_4f,
  input  logic         reset,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [W-1:0] wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (rd_ready && valid_q) valid_d = 1'b0;
    if (wr_valid && !valid_q) begin
      valid_d = 1'b1;
      data_d  = wr_data;
    end
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign wr_ready = !valid_q;
  assign rd_valid = valid_q;
  assign rd_data  = data_q;

endmodule

// File: rtl/word_serializer_param.sv
// Splits IN_W-bit words into RATIO OUT_W-bit slices on the lane clock, with a one-word skid
// buffer so back-to-back words stream gap-free. All outputs are registered.
module word_serializer_param
  import word_ser_pkg::*;
#(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned OUT_W     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned IDLE_FILL = 0
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_first,
  output logic             out_last
);

  localparam int unsigned      RATIO     = IN_W / OUT_W;
  localparam int unsigned      CntW      = cnt_width(RATIO);
  localparam logic [CntW-1:0]  CntLast   = CntW'(RATIO - 1);
  localparam logic [OUT_W-1:0] IdleSlice = OUT_W'(IDLE_FILL);

  if (!params_legal(IN_W, OUT_W)) begin : g_bad_params
    $error("word_serializer_param: IN_W must be a multiple of OUT_W with ratio >= 2");
  end

  ser_state_e       state_q, state_d;
  logic [IN_W-1:0]  sr_q, sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;

  logic in_xfer, out_xfer, last_xfer;
  logic load_in, load_sb, push_sb;

  logic            sb_wr_ready, sb_rd_valid;
  logic [IN_W-1:0] sb_data;

  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid_q && out_ready;
  assign last_xfer = out_xfer && (cnt_q == CntLast);

  word_skid_buf #(
    .W (IN_W)
  ) u_skid (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .wr_valid (push_sb),
    .wr_ready (sb_wr_ready),
    .wr_data  (in_data),
    .rd_valid (sb_rd_valid),
    .rd_ready (load_sb),
    .rd_data  (sb_data)
  );

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_in = 1'b0;
    load_sb = 1'b0;
    push_sb = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          state_d = StActive;
          load_in = 1'b1;
        end
      end
      StActive: begin
        if (last_xfer) begin
          if (in_xfer) load_in = 1'b1;
          else         state_d = StEmpty;
        end else if (in_xfer && sb_wr_ready) begin
          state_d = StFull;
          push_sb = 1'b1;
        end
      end
      StFull: begin
        if (last_xfer && sb_rd_valid) begin
          state_d = StActive;
          load_sb = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Loads only happen at a wrap or from EMPTY, so the counter is already heading to zero.
  always_comb begin
    sr_d = sr_q;
    if (load_in)      sr_d = in_data;
    else if (load_sb) sr_d = sb_data;

    cnt_d = cnt_q;
    if (last_xfer)     cnt_d = '0;
    else if (out_xfer) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    in_ready_d  = (state_d != StFull);
    out_valid_d = (state_d != StEmpty);
    out_data_d  = IdleSlice;
    if (out_valid_d) begin
      out_data_d = OUT_W'(sr_d >> slice_offset(IN_W, OUT_W, 32'(cnt_d), MSB_FIRST));
    end
    out_first_d = out_valid_d && (cnt_d == '0);
    out_last_d  = out_valid_d && (cnt_d == CntLast);
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= IdleSlice;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_word_serializer_param.sv
// Directed bench: default MSB-first 32->8, an LSB-first 32->8 and a 16->4 instance with idle fill.
module tb_word_serializer_param;

  logic clk_4f = 1'b0;
  logic reset;

  logic        a_in_valid, a_in_ready, a_out_ready, a_out_valid, a_out_first, a_out_last;
  logic [31:0] a_in_data;
  logic [7:0]  a_out_data;

  logic        b_in_valid, b_in_ready, b_out_ready, b_out_valid, b_out_first, b_out_last;
  logic [31:0] b_in_data;
  logic [7:0]  b_out_data;

  logic        c_in_valid, c_in_ready, c_out_ready, c_out_valid, c_out_first, c_out_last;
  logic [15:0] c_in_data;
  logic [3:0]  c_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_4f = ~clk_4f;

  word_serializer_param dut_a (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .in_valid  (a_in_valid),
    .in_data   (a_in_data),
    .in_ready  (a_in_ready),
    .out_ready (a_out_ready),
    .out_valid (a_out_valid),
    .out_data  (a_out_data),
    .out_first (a_out_first),
    .out_last  (a_out_last)
  );

  word_serializer_param #(
    .MSB_FIRST (1'b0)
  ) dut_b (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .in_valid  (b_in_valid),
    .in_data   (b_in_data),
    .in_ready  (b_in_ready),
    .out_ready (b_out_ready),
    .out_valid (b_out_valid),
    .out_data  (b_out_data),
    .out_first (b_out_first),
    .out_last  (b_out_last)
  );

  word_serializer_param #(
    .IN_W      (16),
    .OUT_W     (4),
    .IDLE_FILL (32'hA)
  ) dut_c (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .in_valid  (c_in_valid),
    .in_data   (c_in_data),
    .in_ready  (c_in_ready),
    .out_ready (c_out_ready),
    .out_valid (c_out_valid),
    .out_data  (c_out_data),
    .out_first (c_out_first),
    .out_last  (c_out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_slice(input string tag,
                             input logic v, input logic [7:0] d, input logic f, input logic l,
                             input logic ev, input logic [7:0] ed, input logic ef,
                             input logic el);
    check({tag, ".valid"}, 32'(v), 32'(ev));
    check({tag, ".data"},  32'(d), 32'(ed));
    check({tag, ".first"}, 32'(f), 32'(ef));
    check({tag, ".last"},  32'(l), 32'(el));
  endtask

  task automatic step();
    @(posedge clk_4f);
    #1;
  endtask

  logic [7:0] t1_exp [4] = '{8'hFF, 8'hAA, 8'hFF, 8'hBB};
  logic [7:0] t2_exp [7] = '{8'hAA, 8'hFF, 8'hBB, 8'hDD, 8'hCC, 8'hDD, 8'hEE};
  logic [7:0] t3_exp [4] = '{8'h03, 8'h0A, 8'h0F, 8'h01};
  logic [7:0] t5_exp [4] = '{8'h01, 8'h0F, 8'h0A, 8'h03};
  logic [7:0] t6_exp [4] = '{8'h1, 8'h2, 8'h3, 8'h4};

  initial begin
    reset = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst.in_ready", 32'(a_in_ready), 32'd0);
    check_slice("rst.a", a_out_valid, a_out_data, a_out_first, a_out_last, 0, 8'h00, 0, 0);
    check("rst.c_idle", 32'(c_out_data), 32'hA);
    reset = 1'b1;
    step();
    check("rel.in_ready", 32'(a_in_ready), 32'd1);

    // Single word, MSB first
    a_in_valid = 1'b1; a_in_data = 32'hFFAAFFBB;
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_slice($sformatf("t1.s%0d", i), a_out_valid, a_out_data, a_out_first, a_out_last,
                  1, t1_exp[i], i == 0, i == 3);
      step();
    end
    check_slice("t1.idle", a_out_valid, a_out_data, a_out_first, a_out_last, 0, 8'h00, 0, 0);

    // Back-to-back words, second goes through the skid buffer
    a_in_valid = 1'b1; a_in_data = 32'hFFAAFFBB;
    step();
    check_slice("t2.s0", a_out_valid, a_out_data, a_out_first, a_out_last, 1, 8'hFF, 1, 0);
    check("t2.rdy0", 32'(a_in_ready), 32'd1);
    a_in_data = 32'hDDCCDDEE;
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check_slice($sformatf("t2.s%0d", i + 1), a_out_valid, a_out_data, a_out_first,
                  a_out_last, 1, t2_exp[i], i == 3, (i == 2) || (i == 6));
      check($sformatf("t2.rdy%0d", i + 1), 32'(a_in_ready), 32'(i >= 3));
      step();
    end
    check_slice("t2.idle", a_out_valid, a_out_data, a_out_first, a_out_last, 0, 8'h00, 0, 0);

    // LSB first
    b_in_valid = 1'b1; b_in_data = 32'h010F0A03;
    step();
    b_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_slice($sformatf("t3.s%0d", i), b_out_valid, b_out_data, b_out_first, b_out_last,
                  1, t3_exp[i], i == 0, i == 3);
      step();
    end
    check_slice("t3.idle", b_out_valid, b_out_data, b_out_first, b_out_last, 0, 8'h00, 0, 0);

    // Narrow instance with non-zero idle fill
    c_in_valid = 1'b1; c_in_data = 16'h1234;
    step();
    c_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_slice($sformatf("t6.s%0d", i), c_out_valid, 8'(c_out_data), c_out_first,
                  c_out_last, 1, t6_exp[i], i == 0, i == 3);
      step();
    end
    check_slice("t6.idle", c_out_valid, 8'(c_out_data), c_out_first, c_out_last,
                0, 8'h0A, 0, 0);

    // Backpressure while FULL
    a_in_valid = 1'b1; a_in_data = 32'hFFAAFFBB;
    step();
    check_slice("t4.s0", a_out_valid, a_out_data, a_out_first, a_out_last, 1, 8'hFF, 1, 0);
    a_in_data = 32'hDDCCDDEE;
    step();
    a_in_valid = 1'b0;
    check_slice("t4.s1", a_out_valid, a_out_data, a_out_first, a_out_last, 1, 8'hAA, 0, 0);
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_slice($sformatf("t4.hold%0d", i), a_out_valid, a_out_data, a_out_first,
                  a_out_last, 1, 8'hAA, 0, 0);
      check($sformatf("t4.rdy%0d", i), 32'(a_in_ready), 32'd0);
    end
    a_out_ready = 1'b1;
    step();
    check_slice("t4.s2", a_out_valid, a_out_data, a_out_first, a_out_last, 1, 8'hFF, 0, 0);
    step();
    check_slice("t4.s3", a_out_valid, a_out_data, a_out_first, a_out_last, 1, 8'hBB, 0, 1);
    step();
    check_slice("t4.s4", a_out_valid, a_out_data, a_out_first, a_out_last, 1, 8'hDD, 1, 0);
    check("t4.rdy_after", 32'(a_in_ready), 32'd1);

    // Asynchronous reset mid-word
    reset = 1'b0;
    #1;
    check_slice("t5.rst", a_out_valid, a_out_data, a_out_first, a_out_last, 0, 8'h00, 0, 0);
    check("t5.rst_rdy", 32'(a_in_ready), 32'd0);
    step();
    reset = 1'b1;
    step();
    check("t5.rel_rdy", 32'(a_in_ready), 32'd1);
    check_slice("t5.rel", a_out_valid, a_out_data, a_out_first, a_out_last, 0, 8'h00, 0, 0);
    a_in_valid = 1'b1; a_in_data = 32'h010F0A03;
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_slice($sformatf("t5.s%0d", i), a_out_valid, a_out_data, a_out_first, a_out_last,
                  1, t5_exp[i], i == 0, i == 3);
      step();
    end
    check_slice("t5.idle", a_out_valid, a_out_data, a_out_first, a_out_last, 0, 8'h00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
